// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared state encoding and default constants for the PC fetch unit
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10,
    S_TRAP = 2'b11
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP  = 32'd4;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - PC + PC_STEP adder feeding the next-PC mux A input
module pc_incr #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc4
);

  // Natural 32-bit wrap is intended: 32'hFFFF_FFFC + 4 -> 0.
  assign o_pc4 = i_pc + PC_STEP;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and request/ack fetch sequencer; PC_FETCH_MISALIGN_TRAP_EN enables the misalign trap
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST,
  parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] NPC,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] INST,
  output logic        INST_VALID,
  output logic        MISALIGN
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_req;
  logic        w_req_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [31:0] w_pc4;
  logic        w_advance;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic        r_misalign;
  logic        w_misalign_nxt;
`endif

  pc_incr #(
    .PC_STEP (PC_STEP)
  ) u_pc_incr (
    .i_pc  (r_pc),
    .o_pc4 (w_pc4)
  );

  // FLUSH outranks STALL; both only matter once an instruction is held.
  assign w_advance = FLUSH || !STALL;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_inst  <= w_inst_nxt;
      r_valid <= w_valid_nxt;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      r_misalign <= w_misalign_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_req;
    w_inst_nxt  = r_inst;
    w_valid_nxt = r_valid;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    w_misalign_nxt = r_misalign;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        w_req_nxt   = 1'b1;
      end
      S_REQ: begin
        // A started bus access always completes; STALL/FLUSH wait for S_HOLD.
        if (IMEM_ACK) begin
          w_inst_nxt  = IMEM_RDATA;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_advance) begin
          w_inst_nxt  = NOP_INST;
          w_valid_nxt = 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
          if (NPC[1:0] != 2'b00) begin
            w_misalign_nxt = 1'b1;
            w_pc_nxt       = NPC;
            w_req_nxt      = 1'b0;
            w_state_nxt    = S_TRAP;
          end else begin
            w_pc_nxt    = NPC;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_REQ;
          end
`else
          w_pc_nxt    = NPC & ALIGN_MASK;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
`endif
        end
      end
      S_TRAP: begin
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign PC         = r_pc;
  assign PC4        = w_pc4;
  assign IMEM_REQ   = r_req;
  assign IMEM_ADDR  = r_pc;
  assign INST       = r_inst;
  assign INST_VALID = r_valid;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign MISALIGN   = r_misalign;
`else
  assign MISALIGN   = 1'b0;
`endif

endmodule
